syndrome_frame_ctrl: RTL

- Frame sequencer and result buffer for the RS(544,522) 32-lane syndrome unit.
- Accepts a valid/ready stream of 32-symbol beats, counts 17 beats per codeword, and drives `valid`/`start`/`last`/`data` into the syndrome datapath.
- Captures the 22 syndromes at frame end into a one-entry output buffer, with zero-detect, and hands them to the key-equation stage over valid/ready.
- Checks upstream framing and lets the next frame stream while a result is held.

---
 rtl/rs544_ctrl_pkg.sv | 26 ++
 rtl/syndrome_frame_ctrl_if.sv | 34 +++
 rtl/syndrome_result_buf.sv | 64 ++++++
 rtl/syndrome_frame_ctrl.sv | 78 +++++++
 4 files changed

// File: rtl/rs544_ctrl_pkg.sv
// Shared constants and types for the RS(544,522) 32-lane syndrome front end.
// Symbols are GF(2^10); a beat is 32 lanes and a frame is 17 beats.
package rs544_ctrl_pkg;
    localparam int N      = 544;
    localparam int M      = 32;
    localparam int J      = 22;
    localparam int BEATS  = N / M;
    localparam int BEAT_W = $clog2(BEATS);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef logic [9:0] gf_sym_t;
    typedef gf_sym_t [0:M-1] beat_t;
    typedef gf_sym_t [0:J-1] syn_vec_t;

    typedef struct packed {
        syn_vec_t s;
        logic     zero;
        logic     frm_err;
    } syn_res_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;
endpackage

// File: rtl/syndrome_frame_ctrl_if.sv
// Beat stream in, syndrome-unit controls, and the result handshake of syndrome_frame_ctrl.
// master is the surrounding environment, slave is the frame controller.
interface syndrome_frame_ctrl_if;
    import rs544_ctrl_pkg::*;

    logic     in_valid_i;
    logic     in_ready_o;
    logic     in_last_i;
    beat_t    in_data_i;
    logic     syn_valid_o;
    logic     syn_start_o;
    logic     syn_last_o;
    beat_t    syn_data_o;
    logic     syn_s_valid_i;
    syn_vec_t syn_s_i;
    logic     s_valid_o;
    logic     s_ready_i;
    syn_vec_t s_o;
    logic     s_zero_o;
    logic     s_frm_err_o;
    logic     err_o;

    modport master (
        output in_valid_i, in_last_i, in_data_i, syn_s_valid_i, syn_s_i, s_ready_i,
        input  in_ready_o, syn_valid_o, syn_start_o, syn_last_o, syn_data_o,
               s_valid_o, s_o, s_zero_o, s_frm_err_o, err_o
    );

    modport slave (
        input  in_valid_i, in_last_i, in_data_i, syn_s_valid_i, syn_s_i, s_ready_i,
        output in_ready_o, syn_valid_o, syn_start_o, syn_last_o, syn_data_o,
               s_valid_o, s_o, s_zero_o, s_frm_err_o, err_o
    );
endinterface

// File: rtl/syndrome_result_buf.sv
// One-entry syndrome result buffer with zero-detect and frame-error tag.
// Latency: capture strobe to s_valid_o is one cycle.
// Backpressure: holds the result stable until s_ready_i; a same-cycle capture replaces a drained entry.
module syndrome_result_buf
    import rs544_ctrl_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     cap_vld,
    input  syn_vec_t cap_dat,
    input  logic     cap_frm_err,
    output logic     s_valid_o,
    input  logic     s_ready_i,
    output syn_vec_t s_o,
    output logic     s_zero_o,
    output logic     s_frm_err_o
);

    buf_state_t state_q, state_d;
    syn_res_t   res_q;
    logic       load;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BUF_EMPTY;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                res_q.s       <= cap_dat;
                res_q.zero    <= ~|cap_dat;
                res_q.frm_err <= cap_frm_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (cap_vld) begin
                    load    = 1'b1;
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                // Upstream stalls the last beat while we are held, so a capture here always coincides with a drain.
                if (cap_vld) begin
                    load = 1'b1;
                end else if (s_ready_i) begin
                    state_d = BUF_EMPTY;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    assign s_valid_o   = (state_q == BUF_FULL);
    assign s_o         = res_q.s;
    assign s_zero_o    = res_q.zero;
    assign s_frm_err_o = res_q.frm_err;

endmodule

// File: rtl/syndrome_frame_ctrl.sv
// Frame sequencer: counts 17-beat codewords, forwards beats to the syndrome datapath, checks framing.
// Latency: an accepted beat appears on syn_* one cycle later; its result reaches s_* two cycles after the last beat.
// Backpressure: in_ready_o drops only on the last beat while a held result is not being drained.
module syndrome_frame_ctrl
    import rs544_ctrl_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    syndrome_frame_ctrl_if.slave bus
);

    if ((N % M) != 0 || BEATS < 2) begin : g_bad_cfg
        $error("syndrome_frame_ctrl: N must be a multiple of M giving at least two beats");
    end

    logic [BEAT_W-1:0] beat_q;
    logic              at_last;
    logic              accept;
    logic              early_end;
    logic              missing_end;
    logic              syn_valid_q;
    logic              syn_start_q;
    logic              syn_last_q;
    logic              err_q;
    logic              frm_tag_q;
    beat_t             syn_data_q;

    assign at_last        = (beat_q == LAST_BEAT);
    assign bus.in_ready_o = !rst_i && !(at_last && bus.s_valid_o && !bus.s_ready_i);
    assign accept         = bus.in_valid_i && bus.in_ready_o;
    assign early_end      = accept && bus.in_last_i && !at_last;
    assign missing_end    = accept && !bus.in_last_i && at_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q      <= '0;
            syn_valid_q <= 1'b0;
            syn_start_q <= 1'b0;
            syn_last_q  <= 1'b0;
            syn_data_q  <= '0;
            err_q       <= 1'b0;
            frm_tag_q   <= 1'b0;
        end else begin
            if (accept) begin
                // An early end restarts the count so the next beat is forwarded as a frame start.
                beat_q     <= (at_last || bus.in_last_i) ? '0 : beat_q + 1'b1;
                syn_data_q <= bus.in_data_i;
            end
            if (accept && at_last) begin
                frm_tag_q <= !bus.in_last_i;
            end
            syn_valid_q <= accept;
            syn_start_q <= accept && (beat_q == '0);
            syn_last_q  <= accept && at_last;
            err_q       <= early_end || missing_end;
        end
    end

    assign bus.syn_valid_o = syn_valid_q;
    assign bus.syn_start_o = syn_start_q;
    assign bus.syn_last_o  = syn_last_q;
    assign bus.syn_data_o  = syn_data_q;
    assign bus.err_o       = err_q;

    syndrome_result_buf u_result_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cap_vld     (bus.syn_s_valid_i),
        .cap_dat     (bus.syn_s_i),
        .cap_frm_err (frm_tag_q),
        .s_valid_o   (bus.s_valid_o),
        .s_ready_i   (bus.s_ready_i),
        .s_o         (bus.s_o),
        .s_zero_o    (bus.s_zero_o),
        .s_frm_err_o (bus.s_frm_err_o)
    );

endmodule
